// File: rtl/memory_access_stage.sv
// MEM stage: issues loads/stores on a req/ack data bus, stalls upstream while an
// access is outstanding, and owns the MEM/WB register. Optional macro: MEM_ALIGN_CHECK_EN.
module memory_access_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      RegWriteM,
  input  logic                      MemtoRegM,
  input  logic                      MemWriteM,
  input  logic [DATA_WIDTH-1:0]     ALUOutM,
  input  logic [DATA_WIDTH-1:0]     WriteDataM,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegM,
  output logic                      StallM,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      mem_err,
  output logic                      misalign_err,
  output logic                      RegWriteW,
  output logic                      MemtoRegW,
  output logic [DATA_WIDTH-1:0]     ReadDataW,
  output logic [DATA_WIDTH-1:0]     ALUOutW,
  output logic [REG_ADDR_WIDTH-1:0] WriteRegW
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDR_WIDTH-1:0]     r_mem_addr;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic                      r_mem_err;
  logic                      r_reg_write_w;
  logic                      r_mem_to_reg_w;
  logic [DATA_WIDTH-1:0]     r_read_data_w;
  logic [DATA_WIDTH-1:0]     r_alu_out_w;
  logic [REG_ADDR_WIDTH-1:0] r_write_reg_w;

  logic w_access;
  logic w_misalign;
  logic w_idle;
  logic w_busy;
  logic w_start;
  logic w_ack_done;
  logic w_timeout;
  logic w_wb_take;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_misalign   = w_access & (ALUOutM[1:0] != 2'b00);
  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Control decode for the current cycle
  always_comb begin
    w_access   = MemWriteM | MemtoRegM;
    w_idle     = (r_state == S_IDLE);
    w_busy     = (r_state == S_BUSY);
    w_start    = w_idle & w_access & ~w_misalign;
    w_ack_done = w_busy & mem_ack;
    w_timeout  = w_busy & ~mem_ack & (r_cnt == CNT_LAST);
    w_wb_take  = (w_idle & ~w_access) | w_ack_done;
    // Reset gating keeps upstream free while the stage is being cleared
    StallM     = reset & (w_start | (w_busy & ~mem_ack & ~w_timeout));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_err      <= 1'b0;
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
      r_read_data_w  <= '0;
      r_alu_out_w    <= '0;
      r_write_reg_w  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      r_misalign_err <= 1'b0;
`endif
    end else begin
      r_mem_err <= w_timeout;
`ifdef MEM_ALIGN_CHECK_EN
      r_misalign_err <= w_misalign;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MemWriteM;
            r_mem_addr  <= ALUOutM[ADDR_WIDTH-1:0];
            r_mem_wdata <= WriteDataM;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack || w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // MEM/WB: real instruction on completion, bubble otherwise
      if (w_wb_take) begin
        r_reg_write_w  <= RegWriteM;
        r_mem_to_reg_w <= MemtoRegM;
        r_read_data_w  <= (w_busy && MemtoRegM) ? mem_rdata : '0;
        r_alu_out_w    <= ALUOutM;
        r_write_reg_w  <= WriteRegM;
      end else begin
        r_reg_write_w  <= 1'b0;
        r_mem_to_reg_w <= 1'b0;
        r_read_data_w  <= '0;
        r_alu_out_w    <= '0;
        r_write_reg_w  <= '0;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_err   = r_mem_err;
  assign RegWriteW = r_reg_write_w;
  assign MemtoRegW = r_mem_to_reg_w;
  assign ReadDataW = r_read_data_w;
  assign ALUOutW   = r_alu_out_w;
  assign WriteRegW = r_write_reg_w;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: directed ops push expected bus
// requests and MEM/WB writes; a negedge monitor pops and compares them.
module tb_memory_access_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic [4:0]  WriteRegM = '0;
  logic        StallM, mem_req, mem_we, mem_err, misalign_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  memory_access_stage #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .misalign_err(misalign_err),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic rw, input logic mtr, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [4:0] wr);
    wb_t e;
    e.rw = rw; e.mtr = mtr; e.alu = alu; e.rd = rd; e.wr = wr;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  // Monitor: compares every non-bubble MEM/WB value and every bus request
  wb_t  mon_act;
  wb_t  mon_exp;
  bus_t cur_bus;
  logic prev_req = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      mon_act = {RegWriteW, MemtoRegW, ALUOutW, ReadDataW, WriteRegW};
      if (mon_act != '0) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got 0x%0h expected bubble at %0t", mon_act, $time);
        end else begin
          mon_exp = wb_q.pop_front();
          chk("wb_regwrite", 64'(mon_act.rw),  64'(mon_exp.rw));
          chk("wb_memtoreg", 64'(mon_act.mtr), 64'(mon_exp.mtr));
          chk("wb_aluout",   64'(mon_act.alu), 64'(mon_exp.alu));
          chk("wb_readdata", 64'(mon_act.rd),  64'(mon_exp.rd));
          chk("wb_writereg", 64'(mon_act.wr),  64'(mon_exp.wr));
        end
      end
      if (mem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%0h expected no request at %0t", mem_addr, $time);
          cur_bus = {mem_we, mem_addr, mem_wdata};
        end else begin
          cur_bus = bus_q.pop_front();
        end
      end
      if (mem_req) begin
        chk("bus_we",    64'(mem_we),    64'(cur_bus.we));
        chk("bus_addr",  64'(mem_addr),  64'(cur_bus.addr));
        chk("bus_wdata", 64'(mem_wdata), 64'(cur_bus.wdata));
      end
      prev_req = mem_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic drive_nop();
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
  endtask

  // Presents one EX/MEM instruction at posedge+1 and holds it until StallM drops.
  // ack_after = BUSY cycles before the ack cycle (-1: never ack).
  task automatic do_op(input logic rw, input logic mtr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input int ack_after, input logic [31:0] rdata, output int stalls);
    int  b;
    bit  done;
    b = 0; stalls = 0; done = 0;
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    for (int k = 0; k < 60 && !done; k++) begin
      if (mem_req) b++;
      mem_ack   = mem_req && (ack_after >= 0) && (b == ack_after + 1);
      mem_rdata = mem_ack ? rdata : 32'hFFFF_FFFF;
      @(negedge clock);
      if (StallM) stalls++;
      else done = 1;
      @(posedge clock); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_budget: got stall still high expected release within 60 cycles");
    end
    mem_ack = 1'b0;
    drive_nop();
  endtask

  int st;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_stall",   64'(StallM),  64'd0);
    chk("rst_wb",      64'({RegWriteW, MemtoRegW, ALUOutW, ReadDataW, WriteRegW}), 64'd0);
    chk("rst_errs",    64'({mem_err, misalign_err}), 64'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // ALU op: one-cycle pass-through, no stall
    push_wb(1'b1, 1'b0, 32'h1234, 32'h0, 5'd5);
    do_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, -1, 32'h0, st);
    chk("alu_stall", 64'(st), 64'd0);
    chk("alu_wb_next_edge", 64'({RegWriteW, ALUOutW, WriteRegW}), {26'd0, 1'b1, 32'h1234, 5'd5});

    // Load, ack three cycles after request
    push_bus(1'b0, 32'h40, 32'h0);
    push_wb(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 5'd7);
    do_op(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 3, 32'hDEADBEEF, st);
    chk("load_stall_cycles", 64'(st), 64'd4);

    // Store, ack in first BUSY cycle
    push_bus(1'b1, 32'h80, 32'hA5A5A5A5);
    push_wb(1'b0, 1'b0, 32'h80, 32'h0, 5'd0);
    do_op(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 0, 32'h12345678, st);
    chk("store_stall_cycles", 64'(st), 64'd1);
    chk("store_regwrite", 64'(RegWriteW), 64'd0);

    // Timeout: no ack, abort after 16 BUSY cycles
    push_bus(1'b0, 32'h100, 32'h0);
    do_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, -1, 32'h0, st);
    chk("timeout_stall_cycles", 64'(st), 64'd16);
    chk("timeout_err_pulse", 64'(mem_err), 64'd1);
    chk("timeout_req_drop",  64'(mem_req), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    chk("timeout_err_width", 64'(mem_err), 64'd0);
    chk("late_ack_no_req",   64'(mem_req), 64'd0);
    chk("late_ack_no_wb",    64'(RegWriteW), 64'd0);

    // Address with low bits set
`ifdef MEM_ALIGN_CHECK_EN
    do_op(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd3, 0, 32'h11112222, st);
    chk("misalign_stall", 64'(st), 64'd0);
    chk("misalign_pulse", 64'(misalign_err), 64'd1);
    chk("misalign_no_req", 64'(mem_req), 64'd0);
    @(posedge clock); #1;
    chk("misalign_width", 64'(misalign_err), 64'd0);
`else
    push_bus(1'b0, 32'h42, 32'h0);
    push_wb(1'b1, 1'b1, 32'h42, 32'h11112222, 5'd3);
    do_op(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd3, 1, 32'h11112222, st);
    chk("unaligned_stall", 64'(st), 64'd2);
    chk("misalign_tied", 64'(misalign_err), 64'd0);
`endif

    // Back-to-back load, store, ALU op
    push_bus(1'b0, 32'h200, 32'h0);
    push_wb(1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 5'd10);
    push_bus(1'b1, 32'h204, 32'h12345678);
    push_wb(1'b0, 1'b0, 32'h204, 32'h0, 5'd0);
    push_wb(1'b1, 1'b0, 32'h99, 32'h0, 5'd31);
    do_op(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd10, 2, 32'hCAFEF00D, st);
    chk("b2b_load_stall", 64'(st), 64'd3);
    do_op(1'b0, 1'b0, 1'b1, 32'h204, 32'h12345678, 5'd0, 0, 32'h0, st);
    chk("b2b_store_stall", 64'(st), 64'd1);
    do_op(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd31, -1, 32'h0, st);
    chk("b2b_alu_stall", 64'(st), 64'd0);
    repeat (2) @(posedge clock);
    #1;

    // Reset asserted mid-BUSY
    push_bus(1'b0, 32'h300, 32'h0);
    RegWriteM = 1'b1; MemtoRegM = 1'b1; ALUOutM = 32'h300; WriteRegM = 5'd4;
    repeat (3) @(posedge clock);
    #1;
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_req",   64'(mem_req), 64'd0);
    chk("midrst_stall", 64'(StallM),  64'd0);
    chk("midrst_wb",    64'({RegWriteW, MemtoRegW, ALUOutW, ReadDataW, WriteRegW}), 64'd0);
    drive_nop();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    chk("postrst_req",   64'(mem_req), 64'd0);
    chk("postrst_stall", 64'(StallM),  64'd0);
    push_wb(1'b1, 1'b0, 32'hABC, 32'h0, 5'd2);
    do_op(1'b1, 1'b0, 1'b0, 32'hABC, 32'h0, 5'd2, -1, 32'h0, st);
    chk("postrst_alu_stall", 64'(st), 64'd0);
    repeat (2) @(posedge clock);
    #1;

    chk("wb_queue_drained",  64'(wb_q.size()),  64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
